// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, response codes and word-alignment helpers.
// Used by apb_slave_mem and by the APB master side of the bridge.
package apb_pkg;

    localparam logic [0:0] APB_IDLE   = 1'b0;
    localparam logic [0:0] APB_ACCESS = 1'b1;

    localparam logic APB_RESP_OKAY = 1'b0;
    localparam logic APB_RESP_ERR  = 1'b1;

    localparam int APB_ALIGN_BITS = 2;
    localparam int APB_WORD_BYTES = 4;

    function automatic logic apb_misaligned(input logic [APB_ALIGN_BITS-1:0] lsb);
        return lsb != '0;
    endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Access-phase wait-state counter: loads at setup, counts down to zero, flags zero.
// Only instantiated when APB_WAIT_STATE_EN is defined.
module apb_wait_ctr #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_value;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a DEPTH-word flop register file at BASE_ADDR.
// Define APB_WAIT_STATE_EN to insert WAIT_CYCLES access-phase wait states.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'hA000_0000,
    parameter int                WAIT_CYCLES = 2
) (
    input  logic              Pclk,
    input  logic              Presetn,
    input  logic              Psel,
    input  logic              Penable,
    input  logic              Pwrite,
    input  logic [ADDR_W-1:0] Paddr,
    input  logic [DATA_W-1:0] Pdata,
    output logic [DATA_W-1:0] Prdata,
    output logic              Pready,
    output logic              Pslverr
);

    localparam int IDX_W = $clog2(DEPTH);
    // One extra bit so the window limit cannot wrap at the top of the address space.
    localparam logic [ADDR_W:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] LIMIT_EXT = BASE_EXT + (ADDR_W+1)'(APB_WORD_BYTES * DEPTH);

    logic [0:0]        state_reg;
    logic              write_reg;
    logic              err_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] prdata_reg;
    logic [DATA_W-1:0] mem_reg [DEPTH];

    logic              dec_err;
    logic [IDX_W-1:0]  dec_idx;
    logic              setup;
    logic              complete;
    logic              abort;
    logic              ready;
    logic              cnt_zero;

    always_comb begin
        dec_err = apb_misaligned(Paddr[APB_ALIGN_BITS-1:0])
                | ({1'b0, Paddr} < BASE_EXT)
                | ({1'b0, Paddr} >= LIMIT_EXT);
        dec_idx = IDX_W'((Paddr - BASE_ADDR) >> APB_ALIGN_BITS);
    end

    assign setup    = (state_reg == APB_IDLE) && Psel && !Penable;
    assign ready    = (state_reg == APB_ACCESS) && cnt_zero;
    assign complete = ready && Psel && Penable;
    assign abort    = (state_reg == APB_ACCESS) && !Psel;

`ifdef APB_WAIT_STATE_EN
    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    apb_wait_ctr #(
        .CNT_W(CNT_W)
    ) u_wait_ctr (
        .clk        (Pclk),
        .rst_n      (Presetn),
        .load       (setup),
        .clear      (abort),
        .load_value (CNT_W'(WAIT_CYCLES)),
        .zero       (cnt_zero)
    );
`else
    assign cnt_zero = 1'b1;
`endif

    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            state_reg  <= APB_IDLE;
            write_reg  <= 1'b0;
            err_reg    <= 1'b0;
            idx_reg    <= '0;
            wdata_reg  <= '0;
            prdata_reg <= '0;
        end else begin
            case (state_reg)
                APB_IDLE: begin
                    if (setup) begin
                        state_reg <= APB_ACCESS;
                        write_reg <= Pwrite;
                        err_reg   <= dec_err;
                        idx_reg   <= dec_idx;
                        wdata_reg <= Pdata;
                        // Read data is fetched during setup and held until the next read.
                        if (!Pwrite) begin
                            prdata_reg <= dec_err ? '0 : mem_reg[dec_idx];
                        end
                    end
                end
                default: begin
                    if (complete || abort) begin
                        state_reg <= APB_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (complete && write_reg && !err_reg) begin
            mem_reg[idx_reg] <= wdata_reg;
        end
    end

    assign Prdata  = prdata_reg;
    assign Pready  = ready;
    assign Pslverr = (ready && err_reg) ? APB_RESP_ERR : APB_RESP_OKAY;

endmodule
